// File: rtl/logic_gate_pipe.sv
// Registered multi-function bitwise gate with valid/ready on both sides.
// A 2-entry buffer (output register + skid register) keeps in_ready a pure flop.
module logic_gate_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_any,
  output logic             out_all,
  output logic [CNT_W-1:0] txn_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sk_y;
  logic [WIDTH-1:0] fn_y_c;
  logic             accept_c;

  // Gate function applied to the beat currently presented
  always_comb begin
    fn_y_c = '0;
    case (in_op)
      3'd0:    fn_y_c = in_a & in_b;
      3'd1:    fn_y_c = in_a | in_b;
      3'd2:    fn_y_c = in_a ^ in_b;
      3'd3:    fn_y_c = ~(in_a & in_b);
      3'd4:    fn_y_c = ~(in_a | in_b);
      3'd5:    fn_y_c = ~(in_a ^ in_b);
      3'd6:    fn_y_c = ~in_a;
      3'd7:    fn_y_c = in_a;
      default: fn_y_c = '0;
    endcase
  end

  assign accept_c = in_valid & in_ready;

  // Occupancy FSM; out_any/out_all are loaded with every write to out_y
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_y     <= '0;
      out_any   <= 1'b0;
      out_all   <= 1'b0;
      sk_y      <= '0;
      txn_count <= '0;
    end else begin
      if (accept_c && (txn_count != CNT_MAX)) begin
        txn_count <= txn_count + CNT_W'(1);
      end

      case (state)
        ST_EMPTY: begin
          if (accept_c) begin
            out_y     <= fn_y_c;
            out_any   <= |fn_y_c;
            out_all   <= &fn_y_c;
            out_valid <= 1'b1;
            state     <= ST_ONE;
          end
        end

        ST_ONE: begin
          if (out_ready && accept_c) begin
            out_y   <= fn_y_c;
            out_any <= |fn_y_c;
            out_all <= &fn_y_c;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_EMPTY;
          end else if (accept_c) begin
            sk_y     <= fn_y_c;
            in_ready <= 1'b0;
            state    <= ST_FULL;
          end
        end

        ST_FULL: begin
          // in_ready is low here, so no new beat can arrive this edge
          if (out_ready) begin
            out_y    <= sk_y;
            out_any  <= |sk_y;
            out_all  <= &sk_y;
            in_ready <= 1'b1;
            state    <= ST_ONE;
          end
        end

        default: begin
          state     <= ST_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
